// File: rtl/sync_fifo_pkg.sv
// Shared parameters and helpers for the synchronous FIFO buffer.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH    = 4;
  localparam int unsigned DEFAULT_AFULL_THRESH  = 14;
  localparam int unsigned DEFAULT_AEMPTY_THRESH = 2;

  // Pointers carry one extra wrap bit above the RAM address.
  localparam int unsigned PTR_EXTRA_BITS = 1;

  // Ceiling log2, used for sizing occupancy counters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if (v != 0) begin
        result = result + 1;
        v      = v >> 1;
      end
    end
    return result;
  endfunction

  // Pointer width rule: address bits plus the wrap bit.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + PTR_EXTRA_BITS;
  endfunction

  // Pointer type for the default configuration.
  typedef logic [DEFAULT_ADDR_WIDTH+PTR_EXTRA_BITS-1:0] ptr_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// One-clock dual-port RAM: synchronous write port and registered read port.
// The read register resets to zero; the storage array is never cleared.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO on a registered-read RAM with occupancy count,
// full/empty, programmable almost-full/almost-empty and read-valid.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_buffer
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = DEFAULT_AFULL_THRESH,
  parameter int unsigned AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clear,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  // Threshold sanity check at elaboration.
  if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_bad_thresh
    $error("sync_fifo_buffer: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt_c;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic             full_nxt_c;
  logic             empty_nxt_c;

  // Request acceptance: full gates writes, empty gates reads (no fall-through).
  always_comb begin
    wr_acc_c = write_en && !full;
    rd_acc_c = read_en && !empty;
  end

  // Next pointer, occupancy and full/empty state after this edge.
  always_comb begin
    wr_ptr_nxt_c = wr_ptr;
    rd_ptr_nxt_c = rd_ptr;
    count_nxt_c  = CNT_W'(count);
    if (wr_acc_c) begin
      wr_ptr_nxt_c = wr_ptr + PTR_W'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
    end
    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_nxt_c = CNT_W'(count) + CNT_W'(1);
      2'b01:   count_nxt_c = CNT_W'(count) - CNT_W'(1);
      default: count_nxt_c = CNT_W'(count);
    endcase
    full_nxt_c  = (wr_ptr_nxt_c[PTR_W-1] != rd_ptr_nxt_c[PTR_W-1]) &&
                  (wr_ptr_nxt_c[PTR_W-2:0] == rd_ptr_nxt_c[PTR_W-2:0]);
    empty_nxt_c = (wr_ptr_nxt_c == rd_ptr_nxt_c);
  end

  // Pointer, count and status flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt_c;
      rd_ptr       <= rd_ptr_nxt_c;
      count        <= (ADDR_WIDTH + 1)'(count_nxt_c);
      full         <= full_nxt_c;
      empty        <= empty_nxt_c;
      almost_full  <= (count_nxt_c >= CNT_W'(AFULL_THRESH));
      almost_empty <= (count_nxt_c <= CNT_W'(AEMPTY_THRESH));
    end
  end

  // read_valid marks the cycle right after an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_acc_c;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (write_data),
    .rd_en   (rd_acc_c),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (read_data)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !err_clear) || (write_en && full);
      underflow <= (underflow && !err_clear) || (read_en && empty);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer (default 8-bit x 16 configuration).
// A queue model of the FIFO feeds an expected-output scoreboard.
module tb_sync_fifo_buffer;

  logic       clk;
  logic       rst;
  logic       write_en;
  logic [7:0] write_data;
  logic       read_en;
  logic [7:0] read_data;
  logic       read_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       err_clear;
  logic       overflow;
  logic       underflow;
  bit         ovf_m;
  bit         unf_m;
`endif

  int checks;
  int failures;

  logic [7:0] mem_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] last_data;

  sync_fifo_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .write_data   (write_data),
    .read_en      (read_en),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .err_clear    (err_clear),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = mem_q.size();
    check({tag, ".count"},        32'(count),        32'(n));
    check({tag, ".full"},         32'(full),         32'(n == 16));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= 14));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
  endtask

  // One clock cycle of stimulus, then compare against the model.
  task automatic step(input string tag, input logic we, input logic [7:0] wd, input logic re);
    bit acc_w;
    bit acc_r;
    acc_w = we && (mem_q.size() < 16);
    acc_r = re && (mem_q.size() != 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ovf_m = (ovf_m && !err_clear) || (we && (mem_q.size() == 16));
    unf_m = (unf_m && !err_clear) || (re && (mem_q.size() == 0));
`endif
    if (acc_r) exp_q.push_back(mem_q.pop_front());
    if (acc_w) mem_q.push_back(wd);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clear = 1'b0;
    check({tag, ".overflow"},  32'(overflow),  32'(ovf_m));
    check({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
`endif
    check({tag, ".read_valid"}, 32'(read_valid), 32'(acc_r));
    if (acc_r) begin
      last_data = exp_q.pop_front();
    end
    check({tag, ".read_data"}, 32'(read_data), 32'(last_data));
    check_flags(tag);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    write_en   = 1'b0;
    write_data = '0;
    read_en    = 1'b0;
    last_data  = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clear  = 1'b0;
    ovf_m      = 1'b0;
    unf_m      = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("por.read_data", 32'(read_data), 32'h0);
    check("por.read_valid", 32'(read_valid), 32'h0);
    check_flags("por");
    @(negedge clk);
    rst = 1'b0;

    // 1. Reset mid-stream with 5 words queued and read_valid high.
    for (int i = 0; i < 6; i++) step("t1.wr", 1'b1, 8'(8'h40 + i), 1'b0);
    step("t1.rd", 1'b0, 8'h00, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    mem_q.delete();
    exp_q.delete();
    last_data = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ovf_m = 1'b0;
    unf_m = 1'b0;
`endif
    check("t1.async.read_valid", 32'(read_valid), 32'h0);
    check("t1.async.read_data", 32'(read_data), 32'h0);
    check_flags("t1.async");
    @(negedge clk);
    rst = 1'b0;
    step("t1.rd_after_rst", 1'b0, 8'h00, 1'b1);

    // 2. Fill with 0x00..0x0F, then a rejected 17th write.
    for (int i = 0; i < 16; i++) step("t2.fill", 1'b1, 8'(i), 1'b0);
    step("t2.wr17", 1'b1, 8'hEE, 1'b0);

    // 3. Drain in order.
    for (int i = 0; i < 16; i++) step("t3.drain", 1'b0, 8'h00, 1'b1);

    // 4. Simultaneous read/write at count 8 across the pointer wrap.
    for (int i = 0; i < 8; i++) step("t4.pre", 1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) step("t4.both", 1'b1, 8'(8'h30 + i), 1'b1);
    for (int i = 0; i < 8; i++) step("t4.drain", 1'b0, 8'h00, 1'b1);

    // 5. Boundaries: both requests while empty, then while full.
    step("t5.empty_both", 1'b1, 8'h55, 1'b1);
    step("t5.drain1", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) step("t5.fill", 1'b1, 8'(8'h80 + i), 1'b0);
    step("t5.full_both", 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 15; i++) step("t5.drain", 1'b0, 8'h00, 1'b1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // 6. Sticky overflow/underflow with clear.
    for (int i = 0; i < 16; i++) step("t6.fill", 1'b1, 8'(8'hC0 + i), 1'b0);
    step("t6.ovf", 1'b1, 8'hFF, 1'b0);
    step("t6.ovf_hold", 1'b0, 8'h00, 1'b0);
    err_clear = 1'b1;
    step("t6.ovf_clr_new", 1'b1, 8'hFF, 1'b0);
    err_clear = 1'b1;
    step("t6.ovf_clr", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step("t6.drain", 1'b0, 8'h00, 1'b1);
    step("t6.unf", 1'b0, 8'h00, 1'b1);
    err_clear = 1'b1;
    step("t6.unf_clr_new", 1'b0, 8'h00, 1'b1);
    err_clear = 1'b1;
    step("t6.unf_clr", 1'b0, 8'h00, 1'b0);
`endif

    check("end.scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
